// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: memory-stage bus layout, CP0 register
// addresses, exception codes and the exception vector.
package wb_stage_pkg;

    localparam int unsigned MS_WS_WD = 120;
    localparam int unsigned WS_DS_WD = 39;

    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    localparam logic [7:0] CP0_BADVADDR = 8'h40;
    localparam logic [7:0] CP0_COUNT    = 8'h48;
    localparam logic [7:0] CP0_COMPARE  = 8'h58;
    localparam logic [7:0] CP0_STATUS   = 8'h60;
    localparam logic [7:0] CP0_CAUSE    = 8'h68;
    localparam logic [7:0] CP0_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Memory-to-writeback payload, MSB first (badvaddr occupies [119:88]).
    typedef struct packed {
        logic [31:0] badvaddr;
        logic        bd;
        logic        eret;
        logic [7:0]  cp0_addr;
        logic        dst_is_cp0;
        logic        src_is_cp0;
        logic        except;
        logic [4:0]  exccode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_ws_bus_t;

endpackage

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, plus the
// timer interrupt and the pending-interrupt flag.
module cp0_regfile
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  ext_int_i,
    input  logic        mtc0_we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        exc_commit_i,
    input  logic [4:0]  exccode_i,
    input  logic        exc_bd_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_badvaddr_i,
    input  logic        eret_commit_i,
    output logic [31:0] epc_o,
    output logic        has_int_o
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;

    logic [31:0] status_w;
    logic [31:0] cause_w;

    assign status_w = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_w  = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

    always_comb begin
        rdata_o = 32'h0;
        case (addr_i)
            CP0_BADVADDR: rdata_o = badvaddr_q;
            CP0_COUNT:    rdata_o = count_q;
            CP0_COMPARE:  rdata_o = compare_q;
            CP0_STATUS:   rdata_o = status_w;
            CP0_CAUSE:    rdata_o = cause_w;
            CP0_EPC:      rdata_o = epc_q;
            default:      rdata_o = 32'h0;
        endcase
    end

    assign epc_o     = epc_q;
    assign has_int_o = (|({ip_hw_q, ip_sw_q} & im_q)) && ie_q && !exl_q;

    // Next state: free-running timer first, then software writes, then commits.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        tick_d     = ~tick_q;
        count_d    = tick_q ? count_q + 32'd1 : count_q;
        ip_hw_d    = {ti_q | ext_int_i[5], ext_int_i[4:0]};

        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        if (mtc0_we_i) begin
            case (addr_i)
                CP0_COUNT: count_d = wdata_i;
                CP0_COMPARE: begin
                    compare_d = wdata_i;
                    ti_d      = 1'b0;
                end
                CP0_STATUS: begin
                    im_d  = wdata_i[15:8];
                    exl_d = wdata_i[1];
                    ie_d  = wdata_i[0];
                end
                CP0_CAUSE: ip_sw_d = wdata_i[9:8];
                CP0_EPC:   epc_d   = wdata_i;
                default: ;
            endcase
        end

        if (exc_commit_i) begin
            exl_d     = 1'b1;
            exccode_d = exccode_i;
            // A nested exception keeps the original return point.
            if (!exl_q) begin
                epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            if (exccode_i == EXC_ADEL || exccode_i == EXC_ADES) begin
                badvaddr_d = exc_badvaddr_i;
            end
        end

        if (eret_commit_i) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= 6'h0;
            ip_sw_q    <= 2'h0;
            exccode_q  <= 5'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            tick_q     <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            tick_q     <= tick_d;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: pipeline register, GPR write port, bypass bus, trace outputs,
// exception/ERET commit with flush and redirect.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ms_to_ws_valid,
    input  logic [MS_WS_WD-1:0] ms_to_ws_bus,
    output logic                ws_allowin,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic [WS_DS_WD-1:0] ws_to_ds_bus,
    output logic                flush,
    output logic [31:0]         flush_pc,
    input  logic [5:0]          ext_int_in,
    output logic                has_int,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata
);

    logic       ws_valid_q, ws_valid_d;
    ms_ws_bus_t ws_bus_q, ws_bus_d;
    logic       ws_ready_go;
    logic       exc_commit;
    logic       eret_commit;
    logic       mtc0_we;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_epc;
    logic [31:0] final_result;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;

    // Pipeline register: a flush drops whatever arrives in the same cycle.
    always_comb begin
        ws_valid_d = ws_valid_q;
        ws_bus_d   = ws_bus_q;
        if (flush) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
        end
        if (ms_to_ws_valid && ws_allowin) begin
            ws_bus_d = ms_ws_bus_t'(ms_to_ws_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            ws_bus_q   <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            ws_bus_q   <= ws_bus_d;
        end
    end

    assign exc_commit  = ws_valid_q && ws_bus_q.except;
    assign eret_commit = ws_valid_q && ws_bus_q.eret && !ws_bus_q.except;
    assign mtc0_we     = ws_valid_q && ws_bus_q.dst_is_cp0 && !ws_bus_q.except;

    cp0_regfile u_cp0 (
        .clk            (clk),
        .reset          (reset),
        .ext_int_i      (ext_int_in),
        .mtc0_we_i      (mtc0_we),
        .addr_i         (ws_bus_q.cp0_addr),
        .wdata_i        (ws_bus_q.result),
        .rdata_o        (cp0_rdata),
        .exc_commit_i   (exc_commit),
        .exccode_i      (ws_bus_q.exccode),
        .exc_bd_i       (ws_bus_q.bd),
        .exc_pc_i       (ws_bus_q.pc),
        .exc_badvaddr_i (ws_bus_q.badvaddr),
        .eret_commit_i  (eret_commit),
        .epc_o          (cp0_epc),
        .has_int_o      (has_int)
    );

    assign final_result = ws_bus_q.src_is_cp0 ? cp0_rdata : ws_bus_q.result;

    assign flush    = ws_valid_q && (ws_bus_q.except || ws_bus_q.eret);
    assign flush_pc = ws_bus_q.except ? EXC_VECTOR : cp0_epc;

    assign rf_we        = ws_valid_q && ws_bus_q.gr_we && !ws_bus_q.except;
    assign rf_waddr     = ws_bus_q.dest;
    assign rf_wdata     = final_result;
    assign ws_to_ds_bus = {ws_valid_q, rf_we, ws_bus_q.dest, final_result};

    assign debug_wb_pc       = ws_bus_q.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_bus_q.dest;
    assign debug_wb_rf_wdata = final_result;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a word-level CP0/pipeline model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic         clk;
    logic         reset;
    logic         ms_to_ws_valid;
    logic [119:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [38:0]  ws_to_ds_bus;
    logic         flush;
    logic [31:0]  flush_pc;
    logic [5:0]   ext_int_in;
    logic         has_int;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_to_ds_bus      (ws_to_ds_bus),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .ext_int_in        (ext_int_in),
        .has_int           (has_int),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (whole-register view) ----------------
    typedef struct packed {
        logic         valid;
        logic [119:0] bus;
        logic [31:0]  status;
        logic [31:0]  cause;
        logic [31:0]  epc;
        logic [31:0]  badv;
        logic [31:0]  count;
        logic [31:0]  cmp;
        logic         tick;
    } model_t;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    function automatic logic [31:0] m_cp0(input model_t s, input logic [7:0] a);
        case (a)
            8'h40:   return s.badv;
            8'h48:   return s.count;
            8'h58:   return s.cmp;
            8'h60:   return s.status;
            8'h68:   return s.cause;
            8'h70:   return s.epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_final(input model_t s);
        return s.bus[76] ? m_cp0(s, s.bus[85:78]) : s.bus[63:32];
    endfunction

    function automatic logic m_rf_we(input model_t s);
        return s.valid && s.bus[69] && !s.bus[75];
    endfunction

    function automatic logic m_flush(input model_t s);
        return s.valid && (s.bus[75] || s.bus[86]);
    endfunction

    function automatic logic m_has_int(input model_t s);
        return (|(s.cause[15:8] & s.status[15:8])) && s.status[0] && !s.status[1];
    endfunction

    function automatic model_t step(input model_t s, input logic rst, input logic in_v,
                                    input logic [119:0] in_bus, input logic [5:0] ext);
        model_t n;
        logic [31:0] d;
        logic [4:0] code;
        logic exc, eret, mtc;
        n = s;
        if (rst) begin
            n = '0;
            n.status = 32'h0040_0000;
            return n;
        end
        exc  = s.valid && s.bus[75];
        eret = s.valid && s.bus[86] && !s.bus[75];
        mtc  = s.valid && s.bus[77] && !s.bus[75];
        d    = s.bus[63:32];
        code = s.bus[74:70];

        n.tick  = !s.tick;
        n.count = s.tick ? s.count + 32'd1 : s.count;
        if (s.count == s.cmp) n.cause[30] = 1'b1;
        n.cause[15:10] = {s.cause[30] | ext[5], ext[4:0]};

        if (mtc) begin
            case (s.bus[85:78])
                8'h48: n.count = d;
                8'h58: begin n.cmp = d; n.cause[30] = 1'b0; end
                8'h60: n.status = (s.status & ~STATUS_WMASK) | (d & STATUS_WMASK);
                8'h68: n.cause[9:8] = d[9:8];
                8'h70: n.epc = d;
                default: ;
            endcase
        end
        if (exc) begin
            n.status[1]  = 1'b1;
            n.cause[6:2] = code;
            if (!s.status[1]) begin
                n.epc       = s.bus[87] ? s.bus[31:0] - 32'd4 : s.bus[31:0];
                n.cause[31] = s.bus[87];
            end
            if (code == 5'd4 || code == 5'd5) n.badv = s.bus[119:88];
        end
        if (eret) n.status[1] = 1'b0;

        n.valid = m_flush(s) ? 1'b0 : in_v;
        if (in_v) n.bus = in_bus;
        return n;
    endfunction

    model_t m;
    logic started = 1'b0;

    always @(posedge clk) begin
        m <= step(m, reset, ms_to_ws_valid, ms_to_ws_bus, ext_int_in);
        if (reset) started <= 1'b1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("allowin", 32'(ws_allowin), 32'd1);
            chk("valid", 32'(ws_to_ds_bus[38]), 32'(m.valid));
            chk("rf_we", 32'(rf_we), 32'(m_rf_we(m)));
            chk("wen", 32'(debug_wb_rf_wen), {28'h0, {4{m_rf_we(m)}}});
            chk("flush", 32'(flush), 32'(m_flush(m)));
            chk("has_int", 32'(has_int), 32'(m_has_int(m)));
            if (m.valid) begin
                chk("waddr", 32'(rf_waddr), 32'(m.bus[68:64]));
                chk("wdata", rf_wdata, m_final(m));
                chk("trace_pc", debug_wb_pc, m.bus[31:0]);
                chk("trace_wnum", 32'(debug_wb_rf_wnum), 32'(m.bus[68:64]));
                chk("trace_wdata", debug_wb_rf_wdata, m_final(m));
                chk("bypass_hi", 32'(ws_to_ds_bus[38:32]),
                    32'({m.valid, m_rf_we(m), m.bus[68:64]}));
                chk("bypass_data", ws_to_ds_bus[31:0], m_final(m));
                if (m_flush(m))
                    chk("flush_pc", flush_pc, m.bus[75] ? 32'hBFC0_0380 : m.epc);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [119:0] mk(input logic [31:0] badv, input logic bd, input logic er,
                                        input logic [7:0] ca, input logic dst, input logic src,
                                        input logic ex, input logic [4:0] code, input logic gwe,
                                        input logic [4:0] dest, input logic [31:0] res,
                                        input logic [31:0] pc);
        return {badv, bd, er, ca, dst, src, ex, code, gwe, dest, res, pc};
    endfunction

    function automatic logic [119:0] op_alu(input logic [4:0] dest, input logic [31:0] res);
        return mk(32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b1, dest, res, 32'hBFC0_0100);
    endfunction

    function automatic logic [119:0] op_mfc0(input logic [4:0] dest, input logic [7:0] a);
        return mk(32'h0, 1'b0, 1'b0, a, 1'b0, 1'b1, 1'b0, 5'h0, 1'b1, dest, 32'h0, 32'hBFC0_0104);
    endfunction

    function automatic logic [119:0] op_mtc0(input logic [7:0] a, input logic [31:0] v);
        return mk(32'h0, 1'b0, 1'b0, a, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0, 5'h0, v, 32'hBFC0_0108);
    endfunction

    function automatic logic [119:0] op_exc(input logic [4:0] code, input logic [31:0] pc,
                                            input logic bd, input logic [31:0] badv);
        return mk(badv, bd, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1, code, 1'b1, 5'd7, 32'h0000_DEAD, pc);
    endfunction

    function automatic logic [119:0] op_eret();
        return mk(32'h0, 1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b0, 5'h0, 32'h0, 32'hBFC0_010C);
    endfunction

    // Presents one instruction; returns at the negedge where it sits in writeback.
    task automatic send(input logic [119:0] b);
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = b;
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int wait_cyc;
        reset          = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
        ext_int_in     = 6'h0;
        idle(2);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_has_int", 32'(has_int), 32'd0);
        chk("rst_wen", 32'(debug_wb_rf_wen), 32'd0);
        reset = 1'b0;

        send(op_mfc0(5'd2, CP0_STATUS));
        chk("mfc0_status_rst", rf_wdata, 32'h0040_0000);

        send(op_alu(5'd3, 32'h1234_5678));
        chk("addu_we", 32'(rf_we), 32'd1);
        chk("addu_waddr", 32'(rf_waddr), 32'd3);
        chk("addu_wdata", rf_wdata, 32'h1234_5678);
        chk("addu_wen", 32'(debug_wb_rf_wen), 32'hF);
        chk("addu_flush", 32'(flush), 32'd0);

        send(op_exc(EXC_ADEL, 32'hBFC0_1004, 1'b1, 32'h0000_0003));
        chk("adel_flush", 32'(flush), 32'd1);
        chk("adel_flush_pc", flush_pc, 32'hBFC0_0380);
        chk("adel_rf_we", 32'(rf_we), 32'd0);
        send(op_mfc0(5'd4, CP0_EPC));
        chk("adel_epc", rf_wdata, 32'hBFC0_1000);
        send(op_mfc0(5'd4, CP0_CAUSE));
        chk("adel_cause_bd", 32'(rf_wdata[31]), 32'd1);
        chk("adel_exccode", 32'(rf_wdata[6:2]), 32'd4);
        send(op_mfc0(5'd4, CP0_BADVADDR));
        chk("adel_badvaddr", rf_wdata, 32'h0000_0003);
        send(op_mfc0(5'd4, CP0_STATUS));
        chk("adel_status", rf_wdata, 32'h0040_0002);

        // Back-to-back exceptions while EXL=1: second is squashed, EPC preserved.
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = op_exc(EXC_SYS, 32'hBFC0_0200, 1'b0, 32'h0);
        @(negedge clk);
        ms_to_ws_bus   = op_exc(EXC_BP, 32'hBFC0_0300, 1'b0, 32'h0);
        chk("b2b_first_flush", 32'(flush), 32'd1);
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        chk("b2b_second_dropped", 32'(flush), 32'd0);
        send(op_mfc0(5'd4, CP0_EPC));
        chk("nested_epc", rf_wdata, 32'hBFC0_1000);
        send(op_mfc0(5'd4, CP0_CAUSE));
        chk("nested_exccode", 32'(rf_wdata[6:2]), 32'd8);

        // mtc0 EPC, then ERET followed immediately by an instruction.
        send(op_mtc0(CP0_EPC, 32'hBFC0_2000));
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = op_eret();
        @(negedge clk);
        ms_to_ws_bus   = op_alu(5'd9, 32'h0000_0099);
        chk("eret_flush", 32'(flush), 32'd1);
        chk("eret_flush_pc", flush_pc, 32'hBFC0_2000);
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        chk("eret_shadow_valid", 32'(ws_to_ds_bus[38]), 32'd0);
        chk("eret_shadow_we", 32'(rf_we), 32'd0);
        send(op_mfc0(5'd4, CP0_STATUS));
        chk("eret_status", rf_wdata, 32'h0040_0000);

        // Timer interrupt.
        send(op_mtc0(CP0_COUNT, 32'd0));
        send(op_mtc0(CP0_COMPARE, 32'd10));
        send(op_mtc0(CP0_STATUS, 32'h0000_8001));
        idle(1);
        chk("timer_armed_idle", 32'(has_int), 32'd0);
        wait_cyc = 0;
        while (!has_int && wait_cyc < 60) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("timer_fired", 32'(has_int), 32'd1);
        chk("timer_in_window", 32'(wait_cyc >= 15 && wait_cyc <= 25), 32'd1);
        send(op_mfc0(5'd4, CP0_CAUSE));
        chk("timer_ti", 32'(rf_wdata[30]), 32'd1);
        send(op_mtc0(CP0_COMPARE, 32'd1000));
        idle(2);
        chk("timer_cleared", 32'(has_int), 32'd0);

        // External interrupt line 5 shares IP7 with the timer.
        ext_int_in = 6'b100000;
        idle(2);
        chk("ext_int_set", 32'(has_int), 32'd1);
        ext_int_in = 6'b000000;
        idle(2);
        chk("ext_int_clr", 32'(has_int), 32'd0);

        // Reset with an exception in writeback and another instruction arriving.
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = op_exc(EXC_OV, 32'hBFC0_0400, 1'b0, 32'h0);
        @(negedge clk);
        ms_to_ws_bus   = op_alu(5'd10, 32'hAAAA_5555);
        reset          = 1'b1;
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        reset          = 1'b0;
        chk("rst_mid_we", 32'(rf_we), 32'd0);
        chk("rst_mid_flush", 32'(flush), 32'd0);
        send(op_mfc0(5'd4, CP0_STATUS));
        chk("rst_mid_status", rf_wdata, 32'h0040_0000);
        send(op_mfc0(5'd4, CP0_EPC));
        chk("rst_mid_epc", rf_wdata, 32'h0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Final (writeback) pipeline stage; consumes the memory-stage result bus and drives the GPR write port, forwarding bus and debug trace.
Commits exceptions and ERET: generates the pipeline-wide flush and redirect PC, and owns the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC).
Generates the interrupt-pending flag that decode uses to tag instructions.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, redirect target on any exception
MS_WS_WD, 120, width of ms_to_ws_bus

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ms_to_ws_valid  in  1  memory stage holds a completed instruction
ms_to_ws_bus  in  120  {badvaddr[119:88], bd[87], eret[86], cp0_addr[85:78]={rd,sel}, dst_is_cp0[77], src_is_cp0[76], except[75], exccode[74:70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}
ws_allowin  out  1  stage can accept a new instruction
rf_we  out  1  GPR write enable
rf_waddr  out  5  GPR write index
rf_wdata  out  32  GPR write data
ws_to_ds_bus  out  39  {ws_valid, rf_we, dest[4:0], final_result[31:0]} for bypass/interlock
flush  out  1  clear all younger stages this cycle
flush_pc  out  32  fetch redirect target, valid when flush=1
ext_int_in  in  6  external interrupt lines, level-sensitive
has_int  out  1  enabled interrupt pending
debug_wb_pc  out  32  trace PC
debug_wb_rf_wen  out  4  trace byte write enables
debug_wb_rf_wnum  out  5  trace register index
debug_wb_rf_wdata  out  32  trace data

Behaviour:
- Reset: ws_valid=0; Status=32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0); Cause, EPC, BadVAddr, Count, Compare=0; internal tick=0.
- All outputs are combinational from ws_valid and the latched bus, so reset forces rf_we=0, flush=0, has_int=0, debug_wb_rf_wen=0.
- Handshake: ready_go=1, so ws_allowin = !ws_valid || ready_go (effectively always 1).
- Update priority: flush → ws_valid<=0; else if ws_allowin → ws_valid<=ms_to_ws_valid.
- The bus is latched only when ms_to_ws_valid && ws_allowin.
- Writeback occurs one cycle after acceptance.
- flush = ws_valid && (except || eret).
- flush_pc = except ? EXC_VECTOR : EPC (EPC read before any same-cycle update). Except takes priority over eret.
- final_result = src_is_cp0 ? CP0[cp0_addr] : result. Unmapped CP0 addresses read 0.
- rf_we = ws_valid && gr_we && !except. debug_wb_rf_wen = {4{rf_we}}. debug_wb_pc = pc.
- CP0 addresses: BadVAddr 8'h40, Count 8'h48, Compare 8'h58, Status 8'h60, Cause 8'h68, EPC 8'h70.
- mtc0 write: ws_valid && dst_is_cp0 && !except; data=result.
- Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Count, Compare full; BadVAddr read-only.
- Exception commit (ws_valid && except):
  - Status.EXL<=1; Cause.ExcCode[6:2]<=exccode.
  - If EXL was 0: EPC <= bd ? pc-4 : pc, and Cause.BD[31] <= bd. If EXL was 1, EPC and BD are unchanged.
  - BadVAddr<=badvaddr only for exccode 5'h04 (AdEL) or 5'h05 (AdES).
- ERET commit: Status.EXL<=0.
- Count: tick toggles every cycle; Count increments when tick=1 (once per 2 cycles), wrapping 32'hFFFF_FFFF→0. A same-cycle mtc0 Count overrides the increment.
- Timer: Cause.TI[30] sets when Count==Compare (registered values). An mtc0 Compare clears TI and wins over a same-cycle set.
- Cause.IP[15:10] <= {TI | ext_int_in[5], ext_int_in[4:0]}, sampled every cycle.
- has_int = |(Cause.IP & Status.IM) && Status.IE && !Status.EXL.
- Reset during any operation returns all state to reset values next cycle; an in-flight instruction is dropped without writeback.

Decomposition:
- Shared package: CP0 address constants, exccode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12), EXC_VECTOR, bus width and field offsets.
- Sub-module cp0_regfile holds CP0 state, timer and interrupt logic.
- wb_stage keeps the pipeline register, commit decode and output muxing.

Test Plan:
- addu to r3, result 32'h1234_5678 → next cycle rf_we=1, rf_waddr=3, rf_wdata=32'h1234_5678, debug_wb_rf_wen=4'hF, flush=0.
- Load with except=1, exccode=4, pc=32'hBFC0_1004, bd=1, badvaddr=32'h0000_0003 → flush=1, flush_pc=32'hBFC0_0380, rf_we=0; then EPC=32'hBFC0_1000, Cause[31]=1, ExcCode=4, BadVAddr=3, EXL=1.
- Two back-to-back excepting instructions → the second gets flushed at entry; a later exception with EXL=1 leaves EPC unchanged.
- mtc0 EPC=32'hBFC0_2000, then eret → flush_pc=32'hBFC0_2000, EXL cleared; the instruction latched during the flush cycle has ws_valid=0.
- mtc0 Compare=10, Count=0, Status=32'h0000_8001 → ~20 cycles later TI=1 and has_int=1; mtc0 Compare clears has_int.
- mfc0 from Status after reset → rf_wdata=32'h0040_0000; reset asserted mid-pipeline → no writes, flush=0.
